// File: rtl/hub75_scan_driver.sv
// rtl/hub75_scan_driver.sv - HUB75 row-pair scan driver fed from a synchronous-read frame buffer
module hub75_scan_driver #(
    parameter int COLS       = 32,
    parameter int SCAN_ROWS  = 16,
    parameter int ROW_BITS   = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int ON_CYCLES  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  r_en,
    output logic [ADDR_WIDTH-1:0] r_addr,
    input  logic [15:0]           r_data,
    output logic [5:0]            rgb,
    output logic [ROW_BITS-1:0]   row_addr,
    output logic                  hub_clk,
    output logic                  lat,
    output logic                  oe_n,
    output logic                  frame_done
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ON_W  = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;

    localparam logic [COL_W-1:0]    COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(SCAN_ROWS - 1);
    localparam logic [ON_W-1:0]     ON_LAST  = ON_W'(ON_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SHIFT_LO,
        SHIFT_HI,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t state, state_nxt;

    logic [ROW_BITS-1:0]   row, row_nxt;
    logic [COL_W-1:0]      col, col_nxt;
    logic [ON_W-1:0]       on_cnt;
    logic                  row_end;

    logic                  r_en_d;
    logic [ADDR_WIDTH-1:0] r_addr_d;
    logic [5:0]            rgb_d;
    logic [ROW_BITS-1:0]   row_addr_d;
    logic                  hub_clk_d;
    logic                  lat_d;
    logic                  oe_n_d;
    logic                  frame_done_d;

    // Upper frame-buffer bits carry nothing for the panel.
    logic unused_data_bits;
    assign unused_data_bits = ^r_data[15:6];

    // State register plus scan position and on-time counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            row    <= '0;
            col    <= '0;
            on_cnt <= '0;
        end else begin
            state  <= state_nxt;
            row    <= row_nxt;
            col    <= col_nxt;
            on_cnt <= (state == DISPLAY) ? on_cnt + 1'b1 : '0;
        end
    end

    // Next-state and next scan position; en is only looked at in IDLE and at the end of DISPLAY.
    always_comb begin
        state_nxt = state;
        row_nxt   = row;
        col_nxt   = col;
        row_end   = (state == DISPLAY) && (on_cnt == ON_LAST);
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = FETCH;
                    col_nxt   = '0;
                end
            end
            FETCH:    state_nxt = WAIT;
            WAIT:     state_nxt = SHIFT_LO;
            SHIFT_LO: state_nxt = SHIFT_HI;
            SHIFT_HI: begin
                if (col == COL_LAST) begin
                    state_nxt = BLANK;
                end else begin
                    col_nxt   = col + 1'b1;
                    state_nxt = FETCH;
                end
            end
            BLANK:    state_nxt = LATCH;
            LATCH:    state_nxt = DISPLAY;
            DISPLAY: begin
                if (row_end) begin
                    col_nxt   = '0;
                    row_nxt   = (row == ROW_LAST) ? '0 : row + 1'b1;
                    state_nxt = en ? FETCH : IDLE;
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so every pin comes from a flop.
    always_comb begin
        r_en_d       = (state_nxt == FETCH);
        r_addr_d     = r_addr;
        if (state_nxt == FETCH) begin
            r_addr_d = ADDR_WIDTH'(row_nxt) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(col_nxt);
        end
        rgb_d        = (state == WAIT) ? r_data[5:0] : rgb;
        row_addr_d   = (state_nxt == BLANK) ? row : row_addr;
        hub_clk_d    = (state_nxt == SHIFT_HI);
        lat_d        = (state_nxt == LATCH);
        oe_n_d       = (state_nxt != DISPLAY);
        frame_done_d = row_end && (row == ROW_LAST);
    end

    // Registered panel and memory outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en       <= 1'b0;
            r_addr     <= '0;
            rgb        <= '0;
            row_addr   <= '0;
            hub_clk    <= 1'b0;
            lat        <= 1'b0;
            oe_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            r_en       <= r_en_d;
            r_addr     <= r_addr_d;
            rgb        <= rgb_d;
            row_addr   <= row_addr_d;
            hub_clk    <= hub_clk_d;
            lat        <= lat_d;
            oe_n       <= oe_n_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// tb/tb_hub75_scan_driver.sv - scoreboard bench for hub75_scan_driver
module tb_hub75_scan_driver;

    localparam int COLS       = 4;
    localparam int SCAN_ROWS  = 2;
    localparam int ROW_BITS   = 1;
    localparam int ADDR_WIDTH = 3;
    localparam int ON_CYCLES  = 4;
    localparam int ROW_PERIOD = 4 * COLS + 2 + ON_CYCLES;

    logic                  clk;
    logic                  rst_n;
    logic                  en;
    logic                  r_en;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [15:0]           r_data;
    logic [5:0]            rgb;
    logic [ROW_BITS-1:0]   row_addr;
    logic                  hub_clk;
    logic                  lat;
    logic                  oe_n;
    logic                  frame_done;

    hub75_scan_driver #(
        .COLS(COLS), .SCAN_ROWS(SCAN_ROWS), .ROW_BITS(ROW_BITS),
        .ADDR_WIDTH(ADDR_WIDTH), .ON_CYCLES(ON_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
        .rgb(rgb), .row_addr(row_addr), .hub_clk(hub_clk),
        .lat(lat), .oe_n(oe_n), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:(1 << ADDR_WIDTH) - 1];
    initial r_data = '0;
    always @(posedge clk) if (r_en) r_data <= mem[r_addr];

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t q_fetch[$];
    exp_t q_shift[$];
    exp_t q_lat[$];
    exp_t q_frame[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int left   = 0;
    int mrow   = 0;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event with no expectation / bound expired (cycle %0d)", name, cyc);
    endtask

    // Row-level reference: a row starts whenever the driver is free and en is high,
    // then occupies ROW_PERIOD clocks; rows are visited in order and wrap.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            left = 0;
            mrow = 0;
            q_fetch.delete();
            q_shift.delete();
            q_lat.delete();
            q_frame.delete();
        end else begin
            if (left > 0) left = left - 1;
            if (left == 0 && en) begin
                for (int c = 0; c < COLS; c++) begin
                    int a;
                    a = mrow * COLS + c;
                    q_fetch.push_back('{cyc + 4 * c, a});
                    q_shift.push_back('{cyc + 4 * c + 3, int'(mem[a][5:0])});
                end
                q_lat.push_back('{cyc + 4 * COLS + 1, mrow});
                if (mrow == SCAN_ROWS - 1) q_frame.push_back('{cyc + ROW_PERIOD, 0});
                mrow = (mrow + 1) % SCAN_ROWS;
                left = ROW_PERIOD;
            end
        end
    end

    logic [ROW_BITS-1:0] prev_row_addr = '0;
    logic [5:0]          prev_rgb      = '0;
    int                  oe_run        = 0;

    // Monitor: pops expectations whenever the DUT shows an event, plus per-cycle invariants.
    always @(negedge clk) begin
        exp_t e;
        if (lat) chk("lat_with_oe", int'(oe_n), 1);
        if (row_addr != prev_row_addr) chk("row_addr_change_oe", int'(oe_n), 1);
        if (hub_clk) chk("rgb_stable_hub_clk", int'(rgb), int'(prev_rgb));
        if (lat || !oe_n) chk("hub_clk_quiet", int'(hub_clk), 0);
        prev_row_addr = row_addr;
        prev_rgb      = rgb;

        if (!rst_n) oe_run = 0;
        else if (!oe_n) oe_run++;
        else if (oe_run > 0) begin
            chk("oe_low_len", oe_run, ON_CYCLES);
            oe_run = 0;
        end

        if (r_en) begin
            if (q_fetch.size() == 0) miss("fetch");
            else begin
                e = q_fetch.pop_front();
                chk("fetch_cycle", cyc, e.cyc);
                chk("fetch_addr", int'(r_addr), e.val);
            end
        end
        if (hub_clk) begin
            if (q_shift.size() == 0) miss("shift");
            else begin
                e = q_shift.pop_front();
                chk("shift_cycle", cyc, e.cyc);
                chk("shift_rgb", int'(rgb), e.val);
            end
        end
        if (lat) begin
            if (q_lat.size() == 0) miss("latch");
            else begin
                e = q_lat.pop_front();
                chk("lat_cycle", cyc, e.cyc);
                chk("lat_row_addr", int'(row_addr), e.val);
            end
        end
        if (frame_done) begin
            if (q_frame.size() == 0) miss("frame_done");
            else begin
                e = q_frame.pop_front();
                chk("frame_done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        en    = 1'b1;
        for (int k = 0; k < (1 << ADDR_WIDTH); k++) mem[k] = 16'(k + 1);

        repeat (3) @(negedge clk);
        chk("rst_r_en", int'(r_en), 0);
        chk("rst_r_addr", int'(r_addr), 0);
        chk("rst_rgb", int'(rgb), 0);
        chk("rst_row_addr", int'(row_addr), 0);
        chk("rst_hub_clk", int'(hub_clk), 0);
        chk("rst_lat", int'(lat), 0);
        chk("rst_oe_n", int'(oe_n), 1);
        chk("rst_frame_done", int'(frame_done), 0);
        #1 rst_n = 1'b1;

        // Two full frames with en held high.
        repeat (2 * SCAN_ROWS * ROW_PERIOD + 4) @(negedge clk);

        // Drop en during the second column of row 0.
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (r_en && r_addr == 3'd1) found = 1;
        end
        if (!found) miss("wait_row0_col1");
        en = 1'b0;
        repeat (30) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("idle_r_en", int'(r_en), 0);
            chk("idle_oe_n", int'(oe_n), 1);
            @(negedge clk);
        end
        en = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (r_en) found = 1;
        end
        if (!found) miss("wait_resume");
        else chk("resume_addr", int'(r_addr), 4);

        // Asynchronous reset while the row is being displayed.
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (!oe_n) found = 1;
        end
        if (!found) miss("wait_display");
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_oe_n", int'(oe_n), 1);
        chk("async_rst_lat", int'(lat), 0);
        chk("async_rst_r_en", int'(r_en), 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (r_en) found = 1;
        end
        if (!found) miss("wait_restart");
        else chk("restart_addr", int'(r_addr), 0);

        // Random frame contents and random en toggling.
        for (int it = 0; it < 4; it++) begin
            en = 1'b0;
            repeat (30) @(negedge clk);
            for (int k = 0; k < (1 << ADDR_WIDTH); k++) mem[k] = 16'($urandom);
            en = 1'b1;
            for (int i = 0; i < 150; i++) begin
                @(negedge clk);
                if ($urandom_range(15, 0) == 0) en = ~en;
            end
        end

        en = 1'b0;
        repeat (30) @(negedge clk);
        chk("drain_fetch", q_fetch.size(), 0);
        chk("drain_shift", q_shift.size(), 0);
        chk("drain_lat", q_lat.size(), 0);
        chk("drain_frame", q_frame.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hub75_scan_driver.md
Name: hub75_scan_driver

Overview:
- Consumes the frame-buffer block RAM (synchronous-read memory: r_en/r_addr in, 16-bit r_data out one clock later) and drives a HUB75 LED panel.
- Scans row pairs, fetching one word per column and shifting 6-bit RGB data into the panel.
- Latches each row and enables output for a programmable on-time.
- Sits directly downstream of the memory, between it and the panel connector.

Parameters:
- COLS, 32: columns per row, i.e. words per scan row; must be ≥ 1.
- SCAN_ROWS, 16: scan rows, i.e. row pairs; upper half row r and lower half row r+SCAN_ROWS are driven together.
- ROW_BITS, 4: width of row_addr; 2^ROW_BITS ≥ SCAN_ROWS.
- ADDR_WIDTH, 9: width of r_addr; 2^ADDR_WIDTH ≥ SCAN_ROWS*COLS.
- ON_CYCLES, 64: clocks oe_n is held low per row; must be ≥ 1.

Ports:
- clk, input, 1: system clock; all logic on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- en, input, 1: scan enable; level-sensitive.
- r_en, output, 1: memory read enable.
- r_addr, output, ADDR_WIDTH: memory read address.
- r_data, input, 16: memory read data, valid the cycle after r_en. Bit assignment: [0]=R1, [1]=G1, [2]=B1, [3]=R2, [4]=G2, [5]=B2; [15:6] ignored.
- rgb, output, 6: panel data {B2,G2,R2,B1,G1,R1}.
- row_addr, output, ROW_BITS: panel row select (A,B,C,D...).
- hub_clk, output, 1: panel shift clock.
- lat, output, 1: panel latch, active high.
- oe_n, output, 1: panel output enable, active low.
- frame_done, output, 1: one-cycle pulse at the end of the last scan row.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, row=0, col=0. Outputs: r_en=0, r_addr=0, rgb=0, row_addr=0, hub_clk=0, lat=0, oe_n=1, frame_done=0. All outputs are registered.
- Reset asserted mid-operation: outputs take their reset values immediately; scan restarts at row 0 after release.
- IDLE: outputs quiescent (oe_n=1). en=1 → FETCH with col=0; row is held, so the scan resumes at the current row.
- FETCH: r_en=1, r_addr=row*COLS+col, truncated to ADDR_WIDTH; hub_clk=0. → WAIT.
- WAIT: r_en=0. rgb captures r_data[5:0] at the clock edge ending this state. → SHIFT_LO.
- SHIFT_LO: hub_clk=0 with new rgb stable (setup cycle). → SHIFT_HI.
- SHIFT_HI: hub_clk=1, which the panel samples on its rising edge. If col==COLS-1 → BLANK; otherwise col+1 → FETCH.
- Column cost: exactly 4 clocks. Only hub_clk changes between SHIFT_LO and SHIFT_HI; rgb changes only on entry to SHIFT_LO.
- BLANK (1 clock): oe_n=1, hub_clk=0, row_addr←row. row_addr changes only while oe_n=1. → LATCH.
- LATCH (1 clock): lat=1. → DISPLAY, with lat=0 on exit.
- DISPLAY: oe_n=0 for exactly ON_CYCLES clocks, counted by an on-time counter.
- Leaving DISPLAY: oe_n=1 and col=0. If row==SCAN_ROWS-1, row→0 and frame_done=1 for that one clock; otherwise row+1. Then en=1 → FETCH, else IDLE.
- Row period: 4*COLS + 2 + ON_CYCLES clocks, with no gaps while en stays high.
- en deasserted mid-row: the current row completes, including shift, latch and DISPLAY; the block then enters IDLE. en is only sampled in IDLE and when leaving DISPLAY.
- lat and oe_n low are never asserted in the same cycle. hub_clk is 0 in BLANK, LATCH, DISPLAY and IDLE.

Test Plan:
Common setup: COLS=4, SCAN_ROWS=2, ROW_BITS=1, ADDR_WIDTH=3, ON_CYCLES=4. A behavioural synchronous memory is preloaded with word k = k+1 (0x01..0x08).
- Reset values: hold rst_n=0 with en=1 → every output at its reset value (oe_n=1, all others 0). Release rst_n → first r_en=1 with r_addr=0 on the first FETCH clock.
- Row 0 shift: en=1 → r_addr sequence 0,1,2,3; rgb sampled at each hub_clk rising edge is 0x01,0x02,0x03,0x04. Exactly 4 hub_clk pulses, each one clock high and 4 clocks apart. Then row_addr=0, a 1-clock lat pulse, and 4 clocks of oe_n=0.
- Row 1 and wrap: r_addr 4..7 with rgb 0x05..0x08; row_addr=1 during BLANK. frame_done pulses for exactly one clock at the end of row 1 DISPLAY. The next FETCH uses r_addr=0. Total frame = 2*(16+2+4) = 44 clocks.
- en drop mid-row: deassert en during the 2nd column of row 0 → columns 3 and 4 still shift, latch and DISPLAY complete. Then IDLE with r_en=0 and oe_n=1. Re-assert en → the scan resumes at row 1, r_addr=4.
- Reset mid-DISPLAY: pulse rst_n low while oe_n=0 → oe_n=1 and lat=0 within the same cycle, without waiting for a clock. After release, the scan restarts at row 0, r_addr=0.
- Invariants, checked every cycle throughout all tests: never lat=1 while oe_n=0; row_addr changes only while oe_n=1; rgb stable whenever hub_clk=1.
